battleship_shot_sequencer: RTL and testbench
============================================

Name: battleship_shot_sequencer

Overview:
Sequences one shot per Score press through a single shared combinational square checker. A big bomb visits nine cells serially over that checker. The block accumulates hit, near-miss and miss results, the biggest ship hit and the per-shot hit count, and tracks the big-bomb inventory and unique total hits. It sits between the board switches/KEY and the LED/HEX display drivers, replacing nine parallel checkers with one.

Parameters:
GRID, 10, playable coordinates are 1..GRID; 0 and GRID+1 are off-grid.
MAX_BIG, 3, big bombs available after reset (fits in 2 bits).
SHIP_CELLS, 19, total ship cells on the fixed board; all hit means game over.

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
score  in  1  Score request level, already inverted from KEY[0] so it is active-high
x  in  4  target column
y  in  4  target row
big  in  1  1 = big bomb (3x3 pattern), 0 = single cell
q_valid  out  1  square-checker query is live this cycle
q_x  out  4  queried column
q_y  out  4  queried row
q_ship  in  5  checker result for (q_x,q_y), same cycle; one-hot ship class, 0 = no ship
q_near  in  1  checker result, same cycle; orthogonal neighbour holds a ship
busy  out  1  shot in progress (CHECK or REPORT)
done  out  1  one-cycle pulse when results update
is_hit / is_near_miss / is_miss  out  1 each  latched shot result
biggest_ship  out  5  one-hot highest ship class hit this shot
num_hit  out  4  ship cells covered by this shot, 0..9
big_left  out  2  big bombs remaining
wrong  out  1  last Score request rejected
total_hits  out  5  unique ship cells hit since reset
game_over  out  1  total_hits == SHIP_CELLS

Behaviour:
- Reset values:
  - State = IDLE; all outputs 0, except big_left = MAX_BIG.
  - Internal 100-bit hit_map cleared; score_q = 0.
  - Reset mid-shot aborts the shot; no done pulse is issued.
- Edge detect: score_q <= score every cycle. A request is score & ~score_q, and it is honoured only in IDLE. Requests arriving in CHECK, REPORT or GAMEOVER are dropped, not queued.
- Validation at the request cycle t. The shot is rejected if any of these holds:
  - x or y is outside 1..GRID;
  - big = 1 and big_left = 0.
- On rejection:
  - wrong <= 1 and state stays IDLE.
  - big_left, the result outputs and hit_map are unchanged.
- On acceptance:
  - wrong <= 0; the per-shot accumulators are cleared.
  - x, y and big are captured, so later switch changes are ignored.
  - big_left decrements if big = 1.
  - State goes to CHECK at t+1.
- CHECK runs one cell per cycle with index k:
  - Small bomb: k = 0 only.
  - Big bomb: k = 0..8 in this order: (x,y), (x-1,y), (x+1,y), (x,y-1), (x,y+1), (x-1,y-1), (x-1,y+1), (x+1,y-1), (x+1,y+1).
  - Cycle count is fixed regardless of grid position.
- Off-grid cells (coordinate 0 or GRID+1): q_valid = 0 and the cell contributes nothing. q_x and q_y still show the cell coordinates.
- Per valid cell:
  - hit_acc |= (q_ship != 0).
  - ship_acc |= q_ship.
  - near_acc |= (q_ship == 0) & q_near.
  - num_acc += (q_ship != 0).
  - If q_ship != 0 and hit_map[cell] = 0: set the bit and increment total_hits. Repeat hits are not counted.
- REPORT (one cycle, done = 1), entered from the last CHECK cycle:
  - is_hit = hit_acc; is_miss = ~hit_acc; is_near_miss = near_acc; num_hit = num_acc.
  - biggest_ship = highest set bit of ship_acc, one-hot (priority 5 > 4 > 3 > 2 > 1); 0 if none.
  - Results are visible from the done cycle and held until the next accepted shot updates them.
- Latency from request cycle t: small shot done at t+2; big shot done at t+10. busy is high from t+1 through the done cycle.
- After REPORT:
  - If total_hits == SHIP_CELLS, go to GAMEOVER: game_over = 1, all requests ignored, held until reset.
  - Otherwise go to IDLE.
- Holding score high produces exactly one shot. It must be released and pressed again for the next.

Test Plan:
- Small shot: reset, then x=5, y=3, big=0, pulse score at t -> done at t+2; is_hit=1, biggest_ship=10000, num_hit=1, total_hits=1, big_left=3.
- Near miss: small shot at (5,4) -> is_miss=1, is_hit=0, is_near_miss=1, num_hit=0, biggest_ship=00000.
- Big bomb: x=3, y=2, big=1 -> 9 cycles with q_valid=1, done at t+10; num_hit=9, biggest_ship=10000, big_left=2. Repeat the same shot -> num_hit=9, total_hits unchanged.
- Rejects: x=0 -> wrong=1, no busy, big_left unchanged. Fire three big shots, then a fourth big=1 -> wrong=1 and big_left stays 0; a following valid small shot clears wrong.
- Edge cases:
  - big at (1,1) -> q_valid=0 on the 5 off-grid cells, done still at t+10.
  - score held high for 20 cycles -> exactly one done.
  - reset at t+5 of a big shot -> no done, big_left=3, hit_map cleared.
- Game over: hit all 19 ship cells -> game_over=1 after the final done; further score pulses produce no busy.

Source files
------------

// File: rtl/battleship_shot_sequencer.sv
// rtl/battleship_shot_sequencer.sv - serial shot sequencer over one shared square checker
module battleship_shot_sequencer #(
   parameter int GRID       = 10,
   parameter int MAX_BIG    = 3,
   parameter int SHIP_CELLS = 19
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       score,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       big,
   output logic       q_valid,
   output logic [3:0] q_x,
   output logic [3:0] q_y,
   input  logic [4:0] q_ship,
   input  logic       q_near,
   output logic       busy,
   output logic       done,
   output logic       is_hit,
   output logic       is_near_miss,
   output logic       is_miss,
   output logic [4:0] biggest_ship,
   output logic [3:0] num_hit,
   output logic [1:0] big_left,
   output logic       wrong,
   output logic [4:0] total_hits,
   output logic       game_over
);

   localparam int         IW   = $clog2(GRID * GRID);
   localparam logic [3:0] GMAX = 4'(GRID);

   typedef enum logic [1:0] {IDLE, CHECK, REPORT, GAMEOVER} state_t;

   state_t             state, state_nx;
   logic               score_q;
   logic [3:0]         cx, cy, k, dx, dy, num_acc, num_nx;
   logic               cbig, hit_acc, near_acc, hit_nx, near_nx;
   logic [4:0]         ship_acc, ship_nx;
   logic [GRID*GRID-1:0] hit_map;
   logic [IW-1:0]      cell_idx;
   logic               req, in_range, accept, reject, last, cell_hit, new_hit;

   assign req      = score & ~score_q;
   assign in_range = (x >= 4'd1) && (x <= GMAX) && (y >= 4'd1) && (y <= GMAX);
   assign accept   = (state == IDLE) && req && in_range && !(big && big_left == 2'd0);
   assign reject   = (state == IDLE) && req && !accept;
   assign last     = cbig ? (k == 4'd8) : (k == 4'd0);

   // Offsets are added modulo 16, so 4'hF steps one cell left/up onto the off-grid ring.
   always_comb begin
      dx = 4'd0;
      dy = 4'd0;
      case (k)
         4'd1:    dx = 4'hF;
         4'd2:    dx = 4'd1;
         4'd3:    dy = 4'hF;
         4'd4:    dy = 4'd1;
         4'd5:    begin dx = 4'hF; dy = 4'hF; end
         4'd6:    begin dx = 4'hF; dy = 4'd1; end
         4'd7:    begin dx = 4'd1; dy = 4'hF; end
         4'd8:    begin dx = 4'd1; dy = 4'd1; end
         default: ;
      endcase
   end

   assign q_x      = cx + dx;
   assign q_y      = cy + dy;
   assign q_valid  = (state == CHECK) && (q_x >= 4'd1) && (q_x <= GMAX)
                     && (q_y >= 4'd1) && (q_y <= GMAX);
   assign cell_idx = IW'((int'(q_y) - 1) * GRID + int'(q_x) - 1);
   assign cell_hit = q_valid && (q_ship != 5'd0);
   assign new_hit  = cell_hit && !hit_map[cell_idx];

   assign hit_nx  = hit_acc | cell_hit;
   assign near_nx = near_acc | (q_valid && (q_ship == 5'd0) && q_near);
   assign ship_nx = ship_acc | (q_valid ? q_ship : 5'd0);
   assign num_nx  = num_acc + {3'd0, cell_hit};

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      game_over = 1'b0;
      case (state)
         IDLE:     if (accept) state_nx = CHECK;
         CHECK:    begin
                      busy = 1'b1;
                      if (last) state_nx = REPORT;
                   end
         REPORT:   begin
                      busy     = 1'b1;
                      done     = 1'b1;
                      state_nx = (total_hits == 5'(SHIP_CELLS)) ? GAMEOVER : IDLE;
                   end
         GAMEOVER: game_over = 1'b1;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         score_q      <= 1'b0;
         cx           <= 4'd0;
         cy           <= 4'd0;
         cbig         <= 1'b0;
         k            <= 4'd0;
         hit_acc      <= 1'b0;
         near_acc     <= 1'b0;
         ship_acc     <= 5'd0;
         num_acc      <= 4'd0;
         hit_map      <= '0;
         is_hit       <= 1'b0;
         is_near_miss <= 1'b0;
         is_miss      <= 1'b0;
         biggest_ship <= 5'd0;
         num_hit      <= 4'd0;
         big_left     <= 2'(MAX_BIG);
         wrong        <= 1'b0;
         total_hits   <= 5'd0;
      end else begin
         score_q <= score;
         state   <= state_nx;
         if (reject) wrong <= 1'b1;
         if (accept) begin
            wrong    <= 1'b0;
            cx       <= x;
            cy       <= y;
            cbig     <= big;
            k        <= 4'd0;
            hit_acc  <= 1'b0;
            near_acc <= 1'b0;
            ship_acc <= 5'd0;
            num_acc  <= 4'd0;
            if (big) big_left <= big_left - 2'd1;
         end
         if (state == CHECK) begin
            k        <= k + 4'd1;
            hit_acc  <= hit_nx;
            near_acc <= near_nx;
            ship_acc <= ship_nx;
            num_acc  <= num_nx;
            if (new_hit) begin
               hit_map[cell_idx] <= 1'b1;
               total_hits        <= total_hits + 5'd1;
            end
            // Results are latched from the folded-in last cell so they appear with done.
            if (last) begin
               is_hit       <= hit_nx;
               is_miss      <= ~hit_nx;
               is_near_miss <= near_nx;
               num_hit      <= num_nx;
               if (ship_nx[4])      biggest_ship <= 5'b10000;
               else if (ship_nx[3]) biggest_ship <= 5'b01000;
               else if (ship_nx[2]) biggest_ship <= 5'b00100;
               else if (ship_nx[1]) biggest_ship <= 5'b00010;
               else if (ship_nx[0]) biggest_ship <= 5'b00001;
               else                 biggest_ship <= 5'b00000;
            end
         end
      end
   end

endmodule

// File: tb/tb_battleship_shot_sequencer.sv
// tb/tb_battleship_shot_sequencer.sv - directed bench with a fixed 19-cell board model
module tb_battleship_shot_sequencer;

   logic       clock, reset, score, big;
   logic [3:0] x, y;
   logic       q_valid, q_near;
   logic [3:0] q_x, q_y;
   logic [4:0] q_ship;
   logic       busy, done, is_hit, is_near_miss, is_miss, wrong, game_over;
   logic [4:0] biggest_ship, total_hits;
   logic [3:0] num_hit;
   logic [1:0] big_left;

   int vectors    = 0;
   int miscompares = 0;
   int r_lat, r_nvalid, r_ndone, r_nbusy;

   battleship_shot_sequencer dut (
      .clock(clock), .reset(reset), .score(score), .x(x), .y(y), .big(big),
      .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_ship(q_ship), .q_near(q_near),
      .busy(busy), .done(done), .is_hit(is_hit), .is_near_miss(is_near_miss),
      .is_miss(is_miss), .biggest_ship(biggest_ship), .num_hit(num_hit),
      .big_left(big_left), .wrong(wrong), .total_hits(total_hits), .game_over(game_over)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Board: A(10000) y=3 x1..5, B(01000) y=2 x1..4, C(00100) y=1 x2..4,
   // D(00010) x=8 y6..9, E(00001) y=10 x1..3.
   function automatic logic [4:0] ship_at(input int cx, input int cy);
      if (cy == 3 && cx >= 1 && cx <= 5)  return 5'b10000;
      if (cy == 2 && cx >= 1 && cx <= 4)  return 5'b01000;
      if (cy == 1 && cx >= 2 && cx <= 4)  return 5'b00100;
      if (cx == 8 && cy >= 6 && cy <= 9)  return 5'b00010;
      if (cy == 10 && cx >= 1 && cx <= 3) return 5'b00001;
      return 5'b00000;
   endfunction

   always_comb begin
      q_ship = ship_at(int'(q_x), int'(q_y));
      q_near = (ship_at(int'(q_x) - 1, int'(q_y)) != 5'd0) || (ship_at(int'(q_x) + 1, int'(q_y)) != 5'd0)
            || (ship_at(int'(q_x), int'(q_y) - 1) != 5'd0) || (ship_at(int'(q_x), int'(q_y) + 1) != 5'd0);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; holds score for 'hold' cycles, observes from the next negedge on.
   task automatic shot(input logic [3:0] sx, input logic [3:0] sy, input logic sb, input int hold);
      r_lat = -1; r_nvalid = 0; r_ndone = 0; r_nbusy = 0;
      x = sx; y = sy; big = sb; score = 1'b1;
      for (int n = 1; n <= hold + 14; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (q_valid) r_nvalid++;
         if (busy) r_nbusy++;
         if (done) begin
            r_ndone++;
            if (r_lat < 0) r_lat = n;
         end
         if (n >= hold) score = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; score = 1'b0; x = 4'd0; y = 4'd0; big = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst_big_left", big_left, 2'd3);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_is_hit", is_hit, 1'b0);
      check_eq("rst_total", total_hits, 5'd0);
      check_eq("rst_wrong", wrong, 1'b0);
      check_eq("rst_q_valid", q_valid, 1'b0);

      shot(4'd5, 4'd3, 1'b0, 1);
      check_eq("small_lat", r_lat, 2);
      check_eq("small_nvalid", r_nvalid, 1);
      check_eq("small_is_hit", is_hit, 1'b1);
      check_eq("small_biggest", biggest_ship, 5'b10000);
      check_eq("small_num", num_hit, 4'd1);
      check_eq("small_total", total_hits, 5'd1);
      check_eq("small_big_left", big_left, 2'd3);

      shot(4'd5, 4'd4, 1'b0, 1);
      check_eq("near_is_miss", is_miss, 1'b1);
      check_eq("near_is_hit", is_hit, 1'b0);
      check_eq("near_flag", is_near_miss, 1'b1);
      check_eq("near_num", num_hit, 4'd0);
      check_eq("near_biggest", biggest_ship, 5'b00000);

      shot(4'd10, 4'd10, 1'b0, 1);
      check_eq("corner_lat", r_lat, 2);
      check_eq("corner_near", is_near_miss, 1'b0);
      check_eq("corner_miss", is_miss, 1'b1);

      shot(4'd3, 4'd2, 1'b1, 1);
      check_eq("big_lat", r_lat, 10);
      check_eq("big_nvalid", r_nvalid, 9);
      check_eq("big_nbusy", r_nbusy, 10);
      check_eq("big_num", num_hit, 4'd9);
      check_eq("big_biggest", biggest_ship, 5'b10000);
      check_eq("big_big_left", big_left, 2'd2);
      check_eq("big_total", total_hits, 5'd10);

      shot(4'd3, 4'd2, 1'b1, 1);
      check_eq("rep_num", num_hit, 4'd9);
      check_eq("rep_total", total_hits, 5'd10);
      check_eq("rep_big_left", big_left, 2'd1);

      shot(4'd0, 4'd5, 1'b0, 1);
      check_eq("rej_x0_wrong", wrong, 1'b1);
      check_eq("rej_x0_busy", r_nbusy, 0);
      check_eq("rej_x0_big_left", big_left, 2'd1);
      check_eq("rej_x0_num_kept", num_hit, 4'd9);

      shot(4'd11, 4'd4, 1'b0, 1);
      check_eq("rej_x11_wrong", wrong, 1'b1);
      check_eq("rej_x11_busy", r_nbusy, 0);

      shot(4'd1, 4'd1, 1'b1, 1);
      check_eq("edge_lat", r_lat, 10);
      check_eq("edge_nvalid", r_nvalid, 4);
      check_eq("edge_num", num_hit, 4'd3);
      check_eq("edge_biggest", biggest_ship, 5'b01000);
      check_eq("edge_near", is_near_miss, 1'b1);
      check_eq("edge_total", total_hits, 5'd11);
      check_eq("edge_big_left", big_left, 2'd0);
      check_eq("edge_wrong_clr", wrong, 1'b0);

      shot(4'd5, 4'd5, 1'b1, 1);
      check_eq("nobig_wrong", wrong, 1'b1);
      check_eq("nobig_busy", r_nbusy, 0);
      check_eq("nobig_big_left", big_left, 2'd0);

      shot(4'd1, 4'd3, 1'b0, 1);
      check_eq("after_rej_wrong", wrong, 1'b0);
      check_eq("after_rej_total", total_hits, 5'd12);

      shot(4'd8, 4'd6, 1'b0, 20);
      check_eq("hold_ndone", r_ndone, 1);
      check_eq("hold_total", total_hits, 5'd13);

      do_reset();
      shot(4'd3, 4'd2, 1'b0, 1);
      check_eq("pre_abort_total", total_hits, 5'd1);
      x = 4'd3; y = 4'd2; big = 1'b1; score = 1'b1;
      r_ndone = 0;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) r_ndone++;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; score = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (done) r_ndone++;
      end
      check_eq("abort_ndone", r_ndone, 0);
      check_eq("abort_big_left", big_left, 2'd3);
      check_eq("abort_total", total_hits, 5'd0);
      check_eq("abort_busy", busy, 1'b0);
      shot(4'd3, 4'd2, 1'b0, 1);
      check_eq("abort_map_clr", total_hits, 5'd1);

      shot(4'd3, 4'd2, 1'b1, 1);
      check_eq("go_big1_total", total_hits, 5'd9);
      shot(4'd8, 4'd7, 1'b1, 1);
      check_eq("go_big2_biggest", biggest_ship, 5'b00010);
      check_eq("go_big2_total", total_hits, 5'd12);
      shot(4'd2, 4'd10, 1'b1, 1);
      check_eq("go_big3_biggest", biggest_ship, 5'b00001);
      check_eq("go_big3_nvalid", r_nvalid, 6);
      check_eq("go_big3_total", total_hits, 5'd15);
      shot(4'd1, 4'd2, 1'b0, 1);
      shot(4'd1, 4'd3, 1'b0, 1);
      shot(4'd5, 4'd3, 1'b0, 1);
      check_eq("go_pre_total", total_hits, 5'd18);
      check_eq("go_pre_flag", game_over, 1'b0);
      shot(4'd8, 4'd9, 1'b0, 1);
      check_eq("go_last_lat", r_lat, 2);
      check_eq("go_total", total_hits, 5'd19);
      check_eq("go_flag", game_over, 1'b1);
      shot(4'd5, 4'd5, 1'b0, 1);
      check_eq("go_ignore_busy", r_nbusy, 0);
      check_eq("go_ignore_done", r_ndone, 0);
      check_eq("go_hold_flag", game_over, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
